// File: rtl/mid_bram_rd_ctrl_if.sv
// mid_bram_rd_ctrl_if
//   Bundles the read-sequencer signals between the intermediate line buffer
//   (four banks, channels a/b/c), the sequencer and the 2x2 pooling stage.
//
//   Signals (direction seen from the sequencer, modport "slave"):
//     start_rd, fin_rd, bram_toggle        in   control from the line buffer
//     qa_0..qc_3                           in   bank read data (21 bits)
//     in0_rden..in3_rden, rd_addr          out  bank read enables / address
//     top_a..c, bot_a..c, de_out, col_idx  out  aligned row-pair stream
//     busy, overrun                        out  status
//     state_dbg                            out  current sequencer state
//   The "master" modport is the mirror image (line buffer / bench side).
//
//   Handshake: the output stream is valid-only. A beat exists in every clock
//   where de_out=1; the consumer has no ready and must take every beat.
//   fin_rd is a one-clock request pulse with no acknowledge; a request that
//   cannot be queued is dropped and recorded in overrun.
interface mid_bram_rd_ctrl_if;
  logic        start_rd;
  logic        fin_rd;
  logic        bram_toggle;
  logic [20:0] qa_0, qa_1, qa_2, qa_3;
  logic [20:0] qb_0, qb_1, qb_2, qb_3;
  logic [20:0] qc_0, qc_1, qc_2, qc_3;
  logic        in0_rden, in1_rden, in2_rden, in3_rden;
  logic [10:0] rd_addr;
  logic [20:0] top_a, top_b, top_c;
  logic [20:0] bot_a, bot_b, bot_c;
  logic        de_out;
  logic [10:0] col_idx;
  logic        busy;
  logic        overrun;
  logic [2:0]  state_dbg;

  modport master (
    output start_rd, fin_rd, bram_toggle,
    output qa_0, qa_1, qa_2, qa_3, qb_0, qb_1, qb_2, qb_3,
    output qc_0, qc_1, qc_2, qc_3,
    input  in0_rden, in1_rden, in2_rden, in3_rden, rd_addr,
    input  top_a, top_b, top_c, bot_a, bot_b, bot_c,
    input  de_out, col_idx, busy, overrun, state_dbg
  );

  modport slave (
    input  start_rd, fin_rd, bram_toggle,
    input  qa_0, qa_1, qa_2, qa_3, qb_0, qb_1, qb_2, qb_3,
    input  qc_0, qc_1, qc_2, qc_3,
    output in0_rden, in1_rden, in2_rden, in3_rden, rd_addr,
    output top_a, top_b, top_c, bot_a, bot_b, bot_c,
    output de_out, col_idx, busy, overrun, state_dbg
  );
endinterface

// File: rtl/mid_bram_rd_ctrl.sv
// mid_bram_rd_ctrl
//   Read-side sequencer for the 4-bank intermediate line buffer. On each
//   row-pair-complete pulse it selects the finished bank pair (0/1 or 2/3),
//   sweeps rd_addr across one image row and muxes the two banks into aligned
//   top/bottom streams for the pooling stage.
//
//   Ports:
//     clk    in  system clock, posedge
//     RESET  in  asynchronous active-high reset
//     bus    mid_bram_rd_ctrl_if.slave (control, bank data, output stream,
//            status, state_dbg)
//
//   Build option: RD_STRIDE2_EN -- when defined, READ issues only even
//   addresses (IMG_WIDTH/2 beats) for stride-2 column decimation.
//
//   Timing: rden/rd_addr in clock N -> top/bot/de_out/col_idx in N+RD_LAT+1.
module mid_bram_rd_ctrl #(
  parameter logic [10:0] IMG_WIDTH = 11'd28,
  parameter logic [1:0]  RD_LAT    = 2'd1,
  parameter logic [3:0]  START_DLY = 4'd2
) (
  input logic               clk,
  input logic               RESET,
  mid_bram_rd_ctrl_if.slave bus
);

`ifdef RD_STRIDE2_EN
  localparam logic [10:0] BEATS  = IMG_WIDTH >> 1;
  localparam int          ASHIFT = 1;
`else
  localparam logic [10:0] BEATS  = IMG_WIDTH;
  localparam int          ASHIFT = 0;
`endif
  localparam int LAT = int'(RD_LAT);

  typedef enum logic [2:0] {IDLE, SEL, WAIT, READ, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;           // WAIT and DRAIN clock counter
  logic [10:0] col_q, col_d;           // beat index during READ
  logic        sel_q, sel_d;           // 1: banks 0/1, 0: banks 2/3
  logic        pending_q, pending_d;
  logic        pend_sel_q, pend_sel_d; // pair sampled for the queued request
  logic        samp_q, samp_d;         // sample toggle for the queued request
  logic        use_pend_q, use_pend_d; // SEL takes pend_sel instead of toggle
  logic        overrun_q, overrun_d;
  logic        last_drain, rd_issue;

  assign last_drain = (state_q == DRAIN) && (cnt_q == {2'b00, RD_LAT});
  assign rd_issue   = (state_q == READ);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      col_q      <= '0;
      sel_q      <= 1'b0;
      pending_q  <= 1'b0;
      pend_sel_q <= 1'b0;
      samp_q     <= 1'b0;
      use_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      col_q      <= col_d;
      sel_q      <= sel_d;
      pending_q  <= pending_d;
      pend_sel_q <= pend_sel_d;
      samp_q     <= samp_d;
      use_pend_q <= use_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    sel_d      = sel_q;
    pending_d  = pending_q;
    pend_sel_d = pend_sel_q;
    samp_d     = 1'b0;
    use_pend_d = use_pend_q;
    overrun_d  = overrun_q;

    // The toggle settles one clock after fin_rd, so a queued request
    // captures its pair in the clock following the pulse.
    if (samp_q) pend_sel_d = bus.bram_toggle;

    case (state_q)
      IDLE: begin
        if (bus.fin_rd) begin
          state_d    = SEL;
          use_pend_d = 1'b0;
        end
      end
      SEL: begin
        sel_d = use_pend_q ? pend_sel_q : bus.bram_toggle;
        cnt_d = '0;
        col_d = '0;
        state_d = (START_DLY == 4'd0) ? READ : WAIT;
      end
      WAIT: begin
        if (cnt_q == START_DLY - 4'd1) state_d = READ;
        else                           cnt_d   = cnt_q + 4'd1;
      end
      READ: begin
        if (col_q == BEATS - 11'd1) begin
          state_d = DRAIN;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      DRAIN: begin
        if (last_drain) begin
          if (pending_q) begin
            state_d    = SEL;
            use_pend_d = 1'b1;
            pending_d  = 1'b0;
          end else if (bus.fin_rd) begin
            // Exit clock behaves like IDLE: take the pulse as a fresh request.
            state_d    = SEL;
            use_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request while busy: queue one, drop and flag any further one.
    if (bus.fin_rd && (state_q != IDLE) && !(last_drain && !pending_q)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
        samp_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (!bus.start_rd) begin
      state_d    = IDLE;
      cnt_d      = '0;
      col_d      = '0;
      pending_d  = 1'b0;
      samp_d     = 1'b0;
      use_pend_d = 1'b0;
    end
  end

  assign bus.in0_rden  = rd_issue &  sel_q;
  assign bus.in1_rden  = rd_issue &  sel_q;
  assign bus.in2_rden  = rd_issue & ~sel_q;
  assign bus.in3_rden  = rd_issue & ~sel_q;
  assign bus.rd_addr   = rd_issue ? (col_q << ASHIFT) : 11'd0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state_q;

  // Data path: valid/column delay line of RD_LAT stages lines up with the
  // BRAM q, then one output register.
  logic [2:0]  vld_pipe_q;
  logic [10:0] col_pipe_q [3];
  logic        de_q;
  logic [10:0] col_idx_q;
  logic [20:0] top_a_q, top_b_q, top_c_q, bot_a_q, bot_b_q, bot_c_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < 3; i++) col_pipe_q[i] <= '0;
      de_q      <= 1'b0;
      col_idx_q <= '0;
      top_a_q   <= '0;
      top_b_q   <= '0;
      top_c_q   <= '0;
      bot_a_q   <= '0;
      bot_b_q   <= '0;
      bot_c_q   <= '0;
    end else if (!bus.start_rd) begin
      // Abort: flush in-flight reads so no partial beats follow.
      vld_pipe_q <= '0;
      for (int i = 0; i < 3; i++) col_pipe_q[i] <= '0;
      de_q      <= 1'b0;
      col_idx_q <= '0;
      top_a_q   <= '0;
      top_b_q   <= '0;
      top_c_q   <= '0;
      bot_a_q   <= '0;
      bot_b_q   <= '0;
      bot_c_q   <= '0;
    end else begin
      vld_pipe_q    <= {vld_pipe_q[1:0], rd_issue};
      col_pipe_q[0] <= col_q;
      col_pipe_q[1] <= col_pipe_q[0];
      col_pipe_q[2] <= col_pipe_q[1];
      de_q          <= vld_pipe_q[LAT-1];
      if (vld_pipe_q[LAT-1]) begin
        col_idx_q <= col_pipe_q[LAT-1];
        // sel_q cannot change before the last beat is captured: the next
        // SEL follows the final DRAIN clock.
        top_a_q <= sel_q ? bus.qa_0 : bus.qa_2;
        top_b_q <= sel_q ? bus.qb_0 : bus.qb_2;
        top_c_q <= sel_q ? bus.qc_0 : bus.qc_2;
        bot_a_q <= sel_q ? bus.qa_1 : bus.qa_3;
        bot_b_q <= sel_q ? bus.qb_1 : bus.qb_3;
        bot_c_q <= sel_q ? bus.qc_1 : bus.qc_3;
      end
    end
  end

  assign bus.de_out  = de_q;
  assign bus.col_idx = col_idx_q;
  assign bus.top_a   = top_a_q;
  assign bus.top_b   = top_b_q;
  assign bus.top_c   = top_c_q;
  assign bus.bot_a   = bot_a_q;
  assign bus.bot_b   = bot_b_q;
  assign bus.bot_c   = bot_c_q;

endmodule

// File: doc/mid_bram_rd_ctrl.md
Name: mid_bram_rd_ctrl

Overview:
Read-side sequencer for the 4-bank intermediate line buffer (12 x bram_21, banks 0-3, channels a/b/c).
- On each row-pair-complete pulse from the buffer, selects the finished bank pair and sweeps rd_addr across one image row.
- Drives per-bank read enables and muxes the bank outputs into aligned top/bottom row streams for the 2x2 pooling stage that follows.

Parameters:
- IMG_WIDTH, 11'd28: pixels per row; sets the sweep length.
- RD_LAT, 2'd1: BRAM read latency in clocks, from address issue to q valid (1..3).
- START_DLY, 4'd2: idle clocks between the request being accepted and the first address issue.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- start_rd  in  1  enable; when low the block is forced to IDLE and the pending request is cleared.
- fin_rd  in  1  one-clock pulse: a row pair is complete.
- bram_toggle  in  1  bank-pair indicator from the line buffer.
- qa_0..qa_3, qb_0..qb_3, qc_0..qc_3  in  21 each  bank read data.
- in0_rden..in3_rden  out  1 each  bank read enables.
- rd_addr  out  11  shared read address.
- top_a, top_b, top_c  out  21 each  upper-row pixel (even bank of the pair).
- bot_a, bot_b, bot_c  out  21 each  lower-row pixel (odd bank of the pair).
- de_out  out  1  top/bot data valid.
- col_idx  out  11  column index of the current top/bot data.
- busy  out  1  high from request acceptance until the last data beat.
- overrun  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset (asynchronous) and start_rd=0 (synchronous): state=IDLE; all rden=0; rd_addr=0; de_out=0; col_idx=0; busy=0; pending=0; all top/bot outputs=0. overrun is cleared by RESET only.
- Pair select: sample bram_toggle one clock after fin_rd, because the toggle updates on the clock after the pulse.
  - sampled 1 -> banks 0 (top) and 1 (bot).
  - sampled 0 -> banks 2 (top) and 3 (bot).
  - The selection is held in an internal register for the whole sweep.
- FSM:
  - IDLE: on fin_rd -> SEL.
  - SEL (1 clk): latch pair, busy=1 -> WAIT.
  - WAIT: count START_DLY clocks -> READ.
  - READ: assert rden on both selected banks only, rd_addr = 0..IMG_WIDTH-1, one per clock; after the last address -> DRAIN.
  - DRAIN: RD_LAT+1 clocks, all rden=0, rd_addr=0 -> IDLE, or -> SEL if pending=1.
- Data path: rden/rd_addr issued at cycle N produce registered top/bot/de_out/col_idx at cycle N+RD_LAT+1. de_out is high for exactly IMG_WIDTH consecutive clocks per sweep, and col_idx runs 0..IMG_WIDTH-1 in step with it.
- The unselected banks' rden stays 0 throughout.
- busy falls in the same clock as the final de_out beat.
- Request while busy:
  - If pending=0, set pending=1; it is serviced from DRAIN, and the pair is re-sampled one clock after that fin_rd and stored with pending.
  - If pending=1 already, the request is dropped and overrun=1 (sticky).
- fin_rd in the same clock that DRAIN exits to IDLE is treated as a fresh request (IDLE->SEL on the next clock, no loss).
- start_rd falling mid-sweep aborts immediately: rden=0 and de_out=0 in the next clock; no partial data beats follow.
- Address arithmetic: rd_addr is 11 bits and never exceeds IMG_WIDTH-1; no wrap.

Optional Feature:
- RD_STRIDE2_EN defined:
  - READ issues only even addresses 0,2,4..IMG_WIDTH-2 (IMG_WIDTH/2 beats).
  - col_idx counts 0..IMG_WIDTH/2-1.
  - de_out is high for IMG_WIDTH/2 clocks.
  - Used for stride-2 column decimation.
- Undefined: full sweep as above.
- All other timing is identical.

Test Plan:
1. RESET mid-READ (async, between clocks) -> all outputs 0 immediately, state IDLE, overrun=0.
2. start_rd=1, fin_rd pulse, bram_toggle 0->1 next clk, q data=address -> in0/in1_rden high 28 clks starting SEL+1+START_DLY. de_out for 28 clks exactly RD_LAT+1 after first rden. top_a=bot_a=col_idx=0..27. in2/in3_rden stay 0.
3. fin_rd with bram_toggle going 1->0 -> banks 2/3 read; top_x sourced from qx_2, bot_x from qx_3.
4. Second fin_rd during READ -> no overrun; second sweep starts immediately after DRAIN with its own sampled pair. A third fin_rd before then -> overrun=1 and stays 1 until RESET.
5. start_rd dropped at column 10 -> rden=0 and de_out=0 next clk, busy=0; no further de_out.
6. RD_STRIDE2_EN build, IMG_WIDTH=28 -> rd_addr 0,2..26, 14 de_out beats, col_idx 0..13.
